// File: rtl/pipe_mdu_if.sv
// pipe_mdu_if: request/result bundle between the EXE stage and the multiply/divide unit.
// The pipeline side drives requests through master; the MDU implements slave.
interface pipe_mdu_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [2:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             flush;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (output start, op, a, b, flush, input busy, done, hi, lo);
   modport slave  (input start, op, a, b, flush, output busy, done, hi, lo);
endinterface

// File: rtl/pipe_mdu.sv
// pipe_mdu: iterative radix-2 multiply / restoring divide unit with HI/LO registers.
// Optional macro MDU_EARLY_OUT_EN lets multiplies finish once the remaining multiplier bits are zero.
module pipe_mdu #(
   parameter int WIDTH = 32
) (
   input  logic      clock,
   input  logic      reset,
   pipe_mdu_if.slave bus
);
   localparam int CW = $clog2(WIDTH);

   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;

   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   state_t             state;
   logic [CW-1:0]      counter;
   logic [WIDTH-1:0]   hi;
   logic [WIDTH-1:0]   lo;
   logic               done;
   logic               is_div;
   logic               neg_q;
   logic               neg_r;
   logic               div_zero;
   logic [2*WIDTH-1:0] mcand;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   mplier;
   logic [WIDTH-1:0]   rem;
   logic [WIDTH-1:0]   quo;
   logic [WIDTH-1:0]   divisor;

   logic               signed_op;
   logic [WIDTH-1:0]   mag_a;
   logic [WIDTH-1:0]   mag_b;
   logic [2*WIDTH-1:0] prod_next;
   logic [2*WIDTH-1:0] prod_fixed;
   logic [WIDTH:0]     rem_shift;
   logic [WIDTH-1:0]   rem_diff;
   logic               div_ge;
   logic [WIDTH-1:0]   quo_fixed;
   logic [WIDTH-1:0]   rem_fixed;
   logic               early_out;

   // Datapath works on magnitudes; signs are reapplied in FIX.
   // A zero divisor makes every restoring step succeed, so the remainder
   // ends up as |a| and sign correction restores a itself.
   always_comb begin
      signed_op  = ~bus.op[0];
      mag_a      = (signed_op && bus.a[WIDTH-1]) ? -bus.a : bus.a;
      mag_b      = (signed_op && bus.b[WIDTH-1]) ? -bus.b : bus.b;
      prod_next  = mplier[0] ? (prod + mcand) : prod;
      rem_shift  = {rem, quo[WIDTH-1]};
      div_ge     = (rem_shift >= {1'b0, divisor});
      rem_diff   = rem_shift[WIDTH-1:0] - divisor;
      prod_fixed = neg_q ? -prod : prod;
      quo_fixed  = div_zero ? '1 : (neg_q ? -quo : quo);
      rem_fixed  = neg_r ? -rem : rem;
`ifdef MDU_EARLY_OUT_EN
      early_out  = !is_div && (mplier[WIDTH-1:1] == '0);
`else
      early_out  = 1'b0;
`endif
   end

   // Control FSM and all result/working registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         counter  <= '0;
         hi       <= '0;
         lo       <= '0;
         done     <= 1'b0;
         is_div   <= 1'b0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         div_zero <= 1'b0;
         mcand    <= '0;
         prod     <= '0;
         mplier   <= '0;
         rem      <= '0;
         quo      <= '0;
         divisor  <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start && !bus.flush) begin
                  case (bus.op)
                     OP_MULT, OP_MULTU: begin
                        is_div  <= 1'b0;
                        neg_q   <= signed_op && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                        neg_r   <= 1'b0;
                        mcand   <= {{WIDTH{1'b0}}, mag_a};
                        mplier  <= mag_b;
                        prod    <= '0;
                        counter <= CW'(WIDTH - 1);
                        state   <= CALC;
                     end
                     OP_DIV, OP_DIVU: begin
                        is_div   <= 1'b1;
                        neg_q    <= signed_op && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                        neg_r    <= signed_op && bus.a[WIDTH-1];
                        div_zero <= (bus.b == '0);
                        quo      <= mag_a;
                        divisor  <= mag_b;
                        rem      <= '0;
                        counter  <= CW'(WIDTH - 1);
                        state    <= CALC;
                     end
                     OP_MTHI: hi <= bus.a;
                     OP_MTLO: lo <= bus.a;
                     default: ;
                  endcase
               end
            end
            CALC: begin
               if (bus.flush) begin
                  state <= IDLE;
               end else begin
                  if (is_div) begin
                     rem <= div_ge ? rem_diff : rem_shift[WIDTH-1:0];
                     quo <= {quo[WIDTH-2:0], div_ge};
                  end else begin
                     prod   <= prod_next;
                     mcand  <= mcand << 1;
                     mplier <= mplier >> 1;
                  end
                  if (counter == '0 || early_out) begin
                     state <= FIX;
                  end else begin
                     counter <= counter - 1'b1;
                  end
               end
            end
            FIX: begin
               state <= IDLE;
               if (!bus.flush) begin
                  if (is_div) begin
                     hi <= rem_fixed;
                     lo <= quo_fixed;
                  end else begin
                     hi <= prod_fixed[2*WIDTH-1:WIDTH];
                     lo <= prod_fixed[WIDTH-1:0];
                  end
                  done <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy = (state != IDLE);
   assign bus.done = done;
   assign bus.hi   = hi;
   assign bus.lo   = lo;
endmodule

// File: tb/tb_pipe_mdu.sv
// tb_pipe_mdu: randomized and directed checks of pipe_mdu against an arithmetic reference model.
// The model computes HI/LO straight from 64-bit multiply and SV division semantics.
module tb_pipe_mdu;
   localparam int WIDTH = 32;
   localparam int LAT   = WIDTH + 1;

   logic clock = 1'b0;
   logic reset;
   int   errors = 0;
   int   checks = 0;
   logic [31:0] mdlHi = '0;
   logic [31:0] mdlLo = '0;

   pipe_mdu_if #(.WIDTH(WIDTH)) bus ();

   pipe_mdu #(.WIDTH(WIDTH)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   // Every comparison in the bench goes through here.
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
      end
   endtask

   // Reference behaviour for each op code, in plain arithmetic.
   task automatic modelOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] p;
      int          sa, sb;
      case (op)
         3'd0: begin
            p = longint'($signed(a)) * longint'($signed(b));
            {mdlHi, mdlLo} = p;
         end
         3'd1: begin
            p = {32'b0, a} * {32'b0, b};
            {mdlHi, mdlLo} = p;
         end
         3'd2: begin
            sa = $signed(a);
            sb = $signed(b);
            if (b == 32'd0) begin
               mdlLo = 32'hFFFFFFFF; mdlHi = a;
            end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
               mdlLo = 32'h80000000; mdlHi = 32'd0;
            end else begin
               mdlLo = 32'(sa / sb); mdlHi = 32'(sa % sb);
            end
         end
         3'd3: begin
            if (b == 32'd0) begin
               mdlLo = 32'hFFFFFFFF; mdlHi = a;
            end else begin
               mdlLo = a / b; mdlHi = a % b;
            end
         end
         3'd4: mdlHi = a;
         3'd5: mdlLo = a;
         default: ;
      endcase
   endtask

   // Issues one op and, for MULT/DIV, waits out busy (bounded) while optionally
   // poking a start request into the busy window that must be ignored.
   task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input bit intrude);
      int n;
      bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
      @(posedge clock); #1;
      bus.start = 1'b0;
      modelOp(op, a, b);
      if (op <= 3'd3) begin
         n = 0;
         while (bus.busy === 1'b1 && n < 200) begin
            n++;
            if (intrude && n == 3) begin
               bus.start = 1'b1; bus.op = 3'd4; bus.a = 32'hDEADBEEF;
            end
            @(posedge clock); #1;
            bus.start = 1'b0;
         end
`ifdef MDU_EARLY_OUT_EN
         if (op <= 3'd1) checkOutput($sformatf("op%0d latency in range", op), 64'(n >= 2 && n <= LAT), 64'd1);
         else            checkOutput($sformatf("op%0d latency", op), 64'(n), 64'(LAT));
`else
         checkOutput($sformatf("op%0d latency", op), 64'(n), 64'(LAT));
`endif
         checkOutput($sformatf("op%0d done", op), 64'(bus.done), 64'd1);
      end else begin
         checkOutput($sformatf("op%0d busy", op), 64'(bus.busy), 64'd0);
         checkOutput($sformatf("op%0d done", op), 64'(bus.done), 64'd0);
      end
      checkOutput($sformatf("op%0d a=%h b=%h hi", op, a, b), 64'(bus.hi), 64'(mdlHi));
      checkOutput($sformatf("op%0d a=%h b=%h lo", op, a, b), 64'(bus.lo), 64'(mdlLo));
   endtask

   function automatic logic [31:0] randOperand();
      case ($urandom_range(0, 5))
         0:       return 32'd0;
         1:       return 32'd1;
         2:       return 32'hFFFFFFFF;
         3:       return 32'h80000000;
         4:       return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      bit sawDone;
      reset = 1'b1;
      bus.start = 1'b0; bus.op = 3'd0; bus.a = '0; bus.b = '0; bus.flush = 1'b0;
      #12;
      checkOutput("reset busy", 64'(bus.busy), 64'd0);
      checkOutput("reset done", 64'(bus.done), 64'd0);
      checkOutput("reset hi", 64'(bus.hi), 64'd0);
      checkOutput("reset lo", 64'(bus.lo), 64'd0);
      @(posedge clock); #1;
      reset = 1'b0;

      // Directed corner cases from the arithmetic rules.
      applyStimulus(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
      checkOutput("multu max hi", 64'(bus.hi), 64'hFFFFFFFE);
      checkOutput("multu max lo", 64'(bus.lo), 64'h00000001);
      @(posedge clock); #1;
      checkOutput("done single pulse", 64'(bus.done), 64'd0);
      applyStimulus(3'd0, 32'hFFFFFFFD, 32'h00000007, 1'b0);
      checkOutput("mult -3*7 lo", 64'(bus.lo), 64'hFFFFFFEB);
      applyStimulus(3'd2, 32'hFFFFFFF9, 32'd2, 1'b0);
      checkOutput("div -7/2 lo", 64'(bus.lo), 64'hFFFFFFFD);
      checkOutput("div -7/2 hi", 64'(bus.hi), 64'hFFFFFFFF);
      applyStimulus(3'd3, 32'd7, 32'd2, 1'b0);
      applyStimulus(3'd3, 32'd5, 32'd0, 1'b0);
      checkOutput("divu by zero lo", 64'(bus.lo), 64'hFFFFFFFF);
      applyStimulus(3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0);
      checkOutput("div overflow lo", 64'(bus.lo), 64'h80000000);
      applyStimulus(3'd2, 32'hFFFFFFF0, 32'd0, 1'b0);
      applyStimulus(3'd0, 32'h80000000, 32'h80000000, 1'b0);
      // MTLO issued in the same cycle done is high, then a start landing inside busy.
      applyStimulus(3'd3, 32'd100, 32'd9, 1'b0);
      applyStimulus(3'd5, 32'h0BADF00D, 32'd0, 1'b0);
      applyStimulus(3'd1, 32'h12345678, 32'h9ABCDEF0, 1'b1);

      // Flush mid-divide: HI/LO keep MTHI/MTLO values and no done appears.
      applyStimulus(3'd4, 32'h00001234, 32'd0, 1'b0);
      applyStimulus(3'd5, 32'h00005678, 32'd0, 1'b0);
      bus.start = 1'b1; bus.op = 3'd2; bus.a = 32'd100; bus.b = 32'd7;
      @(posedge clock); #1;
      bus.start = 1'b0;
      for (int i = 2; i <= 10; i++) begin
         if (i == 5) begin
            bus.start = 1'b1; bus.op = 3'd4; bus.a = 32'hCAFE0000;
         end
         @(posedge clock); #1;
         bus.start = 1'b0;
      end
      checkOutput("busy before flush", 64'(bus.busy), 64'd1);
      bus.flush = 1'b1;
      @(posedge clock); #1;
      bus.flush = 1'b0;
      checkOutput("flush busy", 64'(bus.busy), 64'd0);
      checkOutput("flush hi", 64'(bus.hi), 64'h00001234);
      checkOutput("flush lo", 64'(bus.lo), 64'h00005678);
      sawDone = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (bus.done === 1'b1) sawDone = 1'b1;
         @(posedge clock); #1;
      end
      checkOutput("flush no done", 64'(sawDone), 64'd0);

      // flush together with start in IDLE drops the request.
      bus.start = 1'b1; bus.flush = 1'b1; bus.op = 3'd4; bus.a = 32'h77777777;
      @(posedge clock); #1;
      checkOutput("idle flush mthi hi", 64'(bus.hi), 64'h00001234);
      bus.op = 3'd3; bus.a = 32'd9; bus.b = 32'd3;
      @(posedge clock); #1;
      bus.start = 1'b0; bus.flush = 1'b0;
      checkOutput("idle flush divu busy", 64'(bus.busy), 64'd0);

      // Randomized sequence scored against the model.
      for (int i = 0; i < 60; i++) begin
         applyStimulus(3'($urandom_range(0, 7)), randOperand(), randOperand(), 1'($urandom_range(0, 1)));
      end

      // Asynchronous reset mid-calculation, then a clean rerun.
      bus.start = 1'b1; bus.op = 3'd1; bus.a = 32'hFFFFFFFF; bus.b = 32'hFFFFFFFF;
      @(posedge clock); #1;
      bus.start = 1'b0;
      repeat (5) begin
         @(posedge clock); #1;
      end
      checkOutput("busy before reset", 64'(bus.busy), 64'd1);
      #3 reset = 1'b1;
      #1;
      checkOutput("async reset busy", 64'(bus.busy), 64'd0);
      checkOutput("async reset done", 64'(bus.done), 64'd0);
      checkOutput("async reset hi", 64'(bus.hi), 64'd0);
      checkOutput("async reset lo", 64'(bus.lo), 64'd0);
      mdlHi = '0; mdlLo = '0;
      @(posedge clock); #1;
      reset = 1'b0;
      applyStimulus(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
